// File: rtl/sample_playback_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_playback_ctrl_if
// Description : Flash read bus between the playback controller and the
//               audio image memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_playback_ctrl_if #(
    parameter int ADDR_W = 23
) ();
    logic              flash_read;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_addr,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_addr,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/sample_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sample_playback_ctrl
// Description : Rate-divided audio playback from a 32-bit flash image, two
//               16-bit samples per word, forward or reverse.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_playback_ctrl #(
    parameter int                ADDR_W    = 23,
    parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF,
    parameter logic [31:0]       MIN_DIV   = 32'd16
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [31:0]           divisor,
    input  wire logic                  play,
    input  wire logic                  dir,
    input  wire logic                  restart,
    sample_playback_ctrl_if.master     flash,
    output logic      [15:0]           sample_out,
    output logic                       sample_valid,
    output logic                       underrun
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DATA = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]       c_count_one = 32'd1;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_half;
    logic              r_word_dir;
    logic              r_restart_pending;
    logic [15:0]       r_second;
    logic [15:0]       r_sample;
    logic              r_sample_valid;
    logic              r_underrun;

    logic [31:0]       w_div_eff;
    logic [32:0]       w_limit;
    logic              w_tick;
    logic [ADDR_W-1:0] w_addr_adv;
    logic [ADDR_W-1:0] w_start_addr;
    logic              w_flash_read;
    logic              w_fetch;
    logic              w_emit_second;
    logic              w_accept;
    logic              w_apply_restart;
    logic              w_drop;

    // Compare is 33 bits wide so 2*div_eff cannot overflow for large divisors.
    assign w_div_eff = (divisor < MIN_DIV) ? MIN_DIV : divisor;
    assign w_limit   = {w_div_eff, 1'b0} - 33'd1;
    assign w_tick    = play && ({1'b0, r_count} >= w_limit);

    // The word in flight advances in the direction it was fetched with.
    assign w_addr_adv = r_word_dir
                      ? ((r_addr == '0)        ? LAST_ADDR : r_addr - c_addr_one)
                      : ((r_addr == LAST_ADDR) ? '0        : r_addr + c_addr_one);
    assign w_start_addr = dir ? LAST_ADDR : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_flash_read    = 1'b0;
        w_fetch         = 1'b0;
        w_emit_second   = 1'b0;
        w_accept        = 1'b0;
        w_apply_restart = 1'b0;
        w_drop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (restart) begin
                    w_apply_restart = 1'b1;
                end else if (w_tick) begin
                    if (!r_half) begin
                        w_fetch      = 1'b1;
                        w_state_next = S_REQ;
                    end else begin
                        w_emit_second = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_flash_read = 1'b1;
                w_drop       = w_tick;
                if (!flash.flash_waitrequest) begin
                    w_state_next = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                w_drop = w_tick;
                if (flash.flash_readdatavalid) begin
                    w_state_next = S_IDLE;
                    // A restart seen during the read discards the returning word.
                    if (r_restart_pending || restart) begin
                        w_apply_restart = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count           <= '0;
            r_addr            <= '0;
            r_half            <= 1'b0;
            r_word_dir        <= 1'b0;
            r_restart_pending <= 1'b0;
            r_second          <= '0;
            r_sample          <= '0;
            r_sample_valid    <= 1'b0;
            r_underrun        <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;

            if (w_apply_restart || w_tick) begin
                r_count <= '0;
            end else if (play) begin
                r_count <= r_count + c_count_one;
            end

            if (w_drop) begin
                r_underrun <= 1'b1;
            end
            if (restart && (r_state != S_IDLE)) begin
                r_restart_pending <= 1'b1;
            end
            if (w_fetch) begin
                r_word_dir <= dir;
            end

            if (w_accept) begin
                r_sample       <= r_word_dir ? flash.flash_readdata[31:16] : flash.flash_readdata[15:0];
                r_second       <= r_word_dir ? flash.flash_readdata[15:0]  : flash.flash_readdata[31:16];
                r_sample_valid <= 1'b1;
                r_half         <= 1'b1;
            end
            if (w_emit_second) begin
                r_sample       <= r_second;
                r_sample_valid <= 1'b1;
                r_half         <= 1'b0;
                r_addr         <= w_addr_adv;
            end

            // Last so that it wins over an underrun or pending set this cycle.
            if (w_apply_restart) begin
                r_addr            <= w_start_addr;
                r_half            <= 1'b0;
                r_underrun        <= 1'b0;
                r_restart_pending <= 1'b0;
            end
        end
    end

    assign flash.flash_read = w_flash_read;
    assign flash.flash_addr = r_addr;
    assign sample_out       = r_sample;
    assign sample_valid     = r_sample_valid;
    assign underrun         = r_underrun;

endmodule
`default_nettype wire
